// File: rtl/morse_pkg.sv
// Shared Morse definitions for the transmitter and the key-decoding receiver.
// Contents: FSM state codes, phase lengths in Morse units, the letter code
// space (A=0 .. Z=25, 31 = word space, 26..30 invalid) and the letter table.
package morse_pkg;

    // FSM state codes
    typedef logic [1:0] morse_state_t;
    localparam morse_state_t ST_IDLE = 2'd0;
    localparam morse_state_t ST_MARK = 2'd1;
    localparam morse_state_t ST_GAP  = 2'd2;
    localparam morse_state_t ST_LGAP = 2'd3;

    // Phase lengths in Morse units
    localparam logic [2:0] DOT_U      = 3'd1;
    localparam logic [2:0] DASH_U     = 3'd3;
    localparam logic [2:0] SYM_GAP_U  = 3'd1;
    localparam logic [2:0] LET_GAP_U  = 3'd3;
    localparam logic [2:0] WORD_GAP_U = 3'd7;

    localparam logic [4:0] CODE_SPACE      = 5'd31;
    localparam logic [4:0] CODE_MAX_LETTER = 5'd25;

    // len = number of symbols; pat bit 1 = dash. The first symbol sent is
    // pat[len-1], the last is pat[0].
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pat;
    } morse_sym_t;

    function automatic morse_sym_t morse_lookup(input logic [4:0] code);
        morse_sym_t r;
        case (code)
            5'd0:    r = {3'd2, 4'b0001};  // A .-
            5'd1:    r = {3'd4, 4'b1000};  // B -...
            5'd2:    r = {3'd4, 4'b1010};  // C -.-.
            5'd3:    r = {3'd3, 4'b0100};  // D -..
            5'd4:    r = {3'd1, 4'b0000};  // E .
            5'd5:    r = {3'd4, 4'b0010};  // F ..-.
            5'd6:    r = {3'd3, 4'b0110};  // G --.
            5'd7:    r = {3'd4, 4'b0000};  // H ....
            5'd8:    r = {3'd2, 4'b0000};  // I ..
            5'd9:    r = {3'd4, 4'b0111};  // J .---
            5'd10:   r = {3'd3, 4'b0101};  // K -.-
            5'd11:   r = {3'd4, 4'b0100};  // L .-..
            5'd12:   r = {3'd2, 4'b0011};  // M --
            5'd13:   r = {3'd2, 4'b0010};  // N -.
            5'd14:   r = {3'd3, 4'b0111};  // O ---
            5'd15:   r = {3'd4, 4'b0110};  // P .--.
            5'd16:   r = {3'd4, 4'b1101};  // Q --.-
            5'd17:   r = {3'd3, 4'b0010};  // R .-.
            5'd18:   r = {3'd3, 4'b0000};  // S ...
            5'd19:   r = {3'd1, 4'b0001};  // T -
            5'd20:   r = {3'd3, 4'b0001};  // U ..-
            5'd21:   r = {3'd4, 4'b0001};  // V ...-
            5'd22:   r = {3'd3, 4'b0011};  // W .--
            5'd23:   r = {3'd4, 4'b1001};  // X -..-
            5'd24:   r = {3'd4, 4'b1011};  // Y -.--
            5'd25:   r = {3'd4, 4'b1100};  // Z --..
            default: r = {3'd0, 4'b0000};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Phase timer for the Morse transmitter.
// A cycle prescaler counts 0..UNIT_CYCLES-1 and ticks on its last cycle; a
// 3-bit unit counter loaded with the phase length is decremented per tick.
// Ports:
//   wiCLK  in  system clock
//   wrst   in  synchronous active-low reset
//   start  in  load a new phase (prescaler to 0, unit count to len)
//   len    in  phase length in units (1..7)
//   run    in  advance the timer this cycle
//   done   out last cycle of the current phase
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       wiCLK,
    input  logic       wrst,
    input  logic       start,
    input  logic [2:0] len,
    input  logic       run,
    output logic       done
);

    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    units;
    logic          tick;

    assign tick = (cnt == CNT_LAST);
    assign done = run && tick && (units == 3'd1);

    always_ff @(posedge wiCLK) begin
        if (!wrst) begin
            cnt   <= '0;
            units <= '0;
        end else if (start) begin
            cnt   <= '0;
            units <= len;
        end else if (run) begin
            if (tick) begin
                cnt   <= '0;
                units <= units - 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: takes one 5-bit letter code per valid/ready handshake
// and keys wTone with standard Morse timing.
// Ports:
//   wiCLK   in   system clock
//   wrst    in   synchronous active-low reset
//   wCode   in   letter code (A=0..Z=25, 31 = word space, 26..30 invalid)
//   wValid  in   wCode valid
//   wReady  out  a code can be accepted this cycle
//   wAbort  in   abandon the current letter/space, no trailing gap
//   wTone   out  1 = mark (tone/LED on)
//   wBusy   out  letter or space in progress
//   wErr    out  one-cycle pulse after an accepted invalid code
//   wLeft   out  symbols still to send, including the active one
//
// state | meaning
// IDLE  | waiting for a code
// MARK  | tone on for a dot (1U) or dash (3U)
// GAP   | 1U silence between symbols of a letter
// LGAP  | trailing silence: 3U after a letter, 7U for a word space
module morse_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       wiCLK,
    input  logic       wrst,
    input  logic [4:0] wCode,
    input  logic       wValid,
    output logic       wReady,
    input  logic       wAbort,
    output logic       wTone,
    output logic       wBusy,
    output logic       wErr,
    output logic [2:0] wLeft
);

    morse_state_t state, nxt_state;
    logic [2:0]   left_q, nxt_left;
    logic [3:0]   pat_q, nxt_pat;
    logic         err_q, nxt_err;
    logic         tmr_start, tmr_done;
    logic [2:0]   tmr_len;
    logic         accept;
    morse_sym_t   sym;

    assign wReady = (state == ST_IDLE) && !wAbort;
    assign accept = wValid && wReady;
    assign sym    = morse_lookup(wCode);

    assign wTone = (state == ST_MARK);
    assign wBusy = (state != ST_IDLE);
    assign wErr  = err_q;
    assign wLeft = left_q;

    always_comb begin
        nxt_state = state;
        nxt_left  = left_q;
        nxt_pat   = pat_q;
        nxt_err   = 1'b0;
        tmr_start = 1'b0;
        tmr_len   = DOT_U;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (wCode <= CODE_MAX_LETTER) begin
                        nxt_state = ST_MARK;
                        nxt_left  = sym.len;
                        nxt_pat   = sym.pat;
                        tmr_start = 1'b1;
                        tmr_len   = sym.pat[2'(sym.len - 3'd1)] ? DASH_U : DOT_U;
                    end else if (wCode == CODE_SPACE) begin
                        nxt_state = ST_LGAP;
                        nxt_left  = 3'd0;
                        tmr_start = 1'b1;
                        tmr_len   = WORD_GAP_U;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (tmr_done) begin
                    tmr_start = 1'b1;
                    if (left_q > 3'd1) begin
                        nxt_state = ST_GAP;
                        nxt_left  = left_q - 3'd1;
                        tmr_len   = SYM_GAP_U;
                    end else begin
                        nxt_state = ST_LGAP;
                        nxt_left  = 3'd0;
                        tmr_len   = LET_GAP_U;
                    end
                end
            end
            ST_GAP: begin
                // left_q already counts the upcoming symbol
                if (tmr_done) begin
                    nxt_state = ST_MARK;
                    tmr_start = 1'b1;
                    tmr_len   = pat_q[2'(left_q - 3'd1)] ? DASH_U : DOT_U;
                end
            end
            ST_LGAP: begin
                if (tmr_done) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        if ((state != ST_IDLE) && wAbort) begin
            nxt_state = ST_IDLE;
            nxt_left  = 3'd0;
            tmr_start = 1'b0;
        end
    end

    always_ff @(posedge wiCLK) begin
        if (!wrst) begin
            state  <= ST_IDLE;
            left_q <= 3'd0;
            pat_q  <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            state  <= nxt_state;
            left_q <= nxt_left;
            pat_q  <= nxt_pat;
            err_q  <= nxt_err;
        end
    end

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .wiCLK (wiCLK),
        .wrst  (wrst),
        .start (tmr_start),
        .len   (tmr_len),
        .run   (wBusy),
        .done  (tmr_done)
    );

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx with UNIT_CYCLES=4. Expected per-cycle
// outputs are generated from dot/dash strings of the Morse alphabet.
module tb_morse_tx;

    localparam int U = 4;

    logic       wiCLK = 1'b0;
    logic       wrst;
    logic [4:0] wCode;
    logic       wValid;
    logic       wReady;
    logic       wAbort;
    logic       wTone;
    logic       wBusy;
    logic       wErr;
    logic [2:0] wLeft;

    int n_chk  = 0;
    int n_pass = 0;

    string tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};

    // one entry per cycle after the accept edge: {tone,busy,err,ready,left}
    logic [6:0] expq[$];

    morse_tx #(.UNIT_CYCLES(U)) dut (
        .wiCLK  (wiCLK),
        .wrst   (wrst),
        .wCode  (wCode),
        .wValid (wValid),
        .wReady (wReady),
        .wAbort (wAbort),
        .wTone  (wTone),
        .wBusy  (wBusy),
        .wErr   (wErr),
        .wLeft  (wLeft)
    );

    always #5 wiCLK = ~wiCLK;

    function automatic logic [6:0] vec(input logic tone, input logic busy,
                                       input logic err, input logic rdy,
                                       input int left);
        return {tone, busy, err, rdy, 3'(left)};
    endfunction

    function automatic logic [6:0] obs();
        return {wTone, wBusy, wErr, wReady, wLeft};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic build(input int code);
        string s;
        int    n, u;
        expq.delete();
        if (code <= 25) begin
            s = tbl[code];
            n = s.len();
            for (int k = 0; k < n; k++) begin
                u = (s.getc(k) == "-") ? 3 : 1;
                repeat (u * U) expq.push_back(vec(1, 1, 0, 0, n - k));
                if (k < n - 1) repeat (U) expq.push_back(vec(0, 1, 0, 0, n - k - 1));
                else repeat (3 * U) expq.push_back(vec(0, 1, 0, 0, 0));
            end
        end else if (code == 31) begin
            repeat (7 * U) expq.push_back(vec(0, 1, 0, 0, 0));
        end else begin
            expq.push_back(vec(0, 0, 1, 1, 0));
        end
    endtask

    // Accept at edge 0, then check every following cycle against the model.
    // Optional abort / reset at a given cycle stops the letter early.
    task automatic send(input int code, input int abort_at, input int rst_at);
        logic [6:0] e;
        bit         stop;
        build(code);
        @(negedge wiCLK);
        chk($sformatf("idle before code%0d", code), obs(), vec(0, 0, 0, 1, 0));
        wValid = 1'b1;
        wCode  = 5'(code);
        @(posedge wiCLK);
        stop = 1'b0;
        for (int i = 1; i <= expq.size() && !stop; i++) begin
            @(negedge wiCLK);
            e = expq[i-1];
            chk($sformatf("code%0d c%0d", code, i), obs(), e);
            wCode  = 5'($urandom);
            wValid = e[3] ? 1'b0 : 1'($urandom);
            if (i == abort_at && e[5]) begin
                wAbort = 1'b1;
                stop   = 1'b1;
            end
            if (i == rst_at) begin
                wrst = 1'b0;
                stop = 1'b1;
            end
        end
        @(posedge wiCLK);
        #1;
        wAbort = 1'b0;
        wrst   = 1'b1;
        wValid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int code, ab;
        wrst   = 1'b0;
        wValid = 1'b0;
        wAbort = 1'b0;
        wCode  = 5'd0;
        repeat (3) @(posedge wiCLK);
        @(negedge wiCLK);
        chk("reset outs", {wTone, wBusy, wErr, wLeft}, 6'd0);
        @(posedge wiCLK);
        #1 wrst = 1'b1;

        send(4, 0, 0);    // E
        send(0, 0, 0);    // A
        send(16, 0, 0);   // Q
        send(31, 0, 0);   // word space
        send(27, 0, 0);   // invalid
        send(1, 6, 0);    // B aborted at cycle 6
        send(2, 0, 0);    // C accepted right after the abort
        send(3, 0, 10);   // D with reset at cycle 10

        // valid together with abort in IDLE: nothing accepted
        @(negedge wiCLK);
        wValid = 1'b1;
        wAbort = 1'b1;
        wCode  = 5'd4;
        @(posedge wiCLK);
        #1;
        chk("abort idle ready", {30'd0, wReady, wBusy}, 32'd0);
        wValid = 1'b0;
        wAbort = 1'b0;
        @(negedge wiCLK);
        chk("abort idle no accept", obs(), vec(0, 0, 0, 1, 0));

        for (int r = 0; r < 25; r++) begin
            code = int'($urandom_range(31, 0));
            ab   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 1)) : 0;
            send(code, ab, 0);
        end

        @(negedge wiCLK);
        chk("final idle", obs(), vec(0, 0, 0, 1, 0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
